// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one backing-memory port between an instruction-fetch port (IF)
//   and a data port (D). D normally wins arbitration. A starve counter
//   forces an IF grant after STARVE_LIMIT back-to-back D grants taken while
//   IF was waiting. A grant that never sees i_m_ready is aborted after
//   TIMEOUT cycles: the owner receives zero data and o_err pulses.
//
// Parameters
//   STARVE_LIMIT  consecutive D grants allowed while IF waits (1..15)
//   TIMEOUT       grant cycles allowed without i_m_ready (2..255)
//
// Ports
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_if_req, i_if_addr       fetch request / byte address
//   o_if_rdata, o_if_busywait fetched word (registered) / fetch stall
//   i_d_read, i_d_write       data read (4b) / write (3b) encodings
//   i_d_addr, i_d_wdata       data address / write data
//   o_d_rdata, o_d_busywait   data read word (registered) / data stall
//   o_m_read, o_m_write       memory command, nonzero only while granted
//   o_m_addr, o_m_wdata       memory address / write data (registered)
//   i_m_rdata, i_m_ready      memory read data / completion strobe
//   o_err                     one-cycle pulse on a timeout abort

module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic [31:0] o_if_rdata,
  output logic        o_if_busywait,
  input  logic [3:0]  i_d_read,
  input  logic [2:0]  i_d_write,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  output logic [31:0] o_d_rdata,
  output logic        o_d_busywait,
  output logic [3:0]  o_m_read,
  output logic [2:0]  o_m_write,
  output logic [31:0] o_m_addr,
  output logic [31:0] o_m_wdata,
  input  logic [31:0] i_m_rdata,
  input  logic        i_m_ready,
  output logic        o_err
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_IF,
    GRANT_D,
    RESP
  } state_t;

  localparam logic [3:0] LP_STARVE   = 4'(STARVE_LIMIT);
  localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] LP_IF_CMD   = 4'b0010;

  state_t      r_state;
  state_t      w_next;
  logic        r_owner_d;
  logic [3:0]  r_starve;
  logic [7:0]  r_tmo;
  logic [3:0]  r_cmd_read;
  logic [2:0]  r_cmd_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;
  logic        r_err;

  logic        w_d_active;
  logic        w_grant;
  logic        w_d_wins;
  logic        w_timeout;

  assign w_d_active = (|i_d_read) | (|i_d_write);
  assign w_grant    = (r_state == GRANT_IF) || (r_state == GRANT_D);
  assign w_d_wins   = w_d_active && ((r_starve < LP_STARVE) || !i_if_req);
  // The abort fires on the last allowed grant cycle; a same-cycle
  // i_m_ready still counts as a normal completion.
  assign w_timeout  = w_grant && !i_m_ready && (r_tmo == LP_TMO_LAST);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic. RESP always drains back through IDLE so every
  // request is re-arbitrated with fresh inputs.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_d_wins) begin
          w_next = GRANT_D;
        end else if (i_if_req) begin
          w_next = GRANT_IF;
        end
      end
      GRANT_IF, GRANT_D: begin
        if (i_m_ready || w_timeout) begin
          w_next = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Grant bookkeeping: latch the winner's command so later input changes
  // cannot disturb the memory side, track starvation and timeout, and
  // capture read data (or zero on abort) into the owner's result register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_owner_d   <= 1'b0;
      r_starve    <= '0;
      r_tmo       <= '0;
      r_cmd_read  <= '0;
      r_cmd_write <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (r_state == IDLE) begin
        r_tmo <= '0;
        if (w_d_wins) begin
          r_owner_d   <= 1'b1;
          r_cmd_write <= i_d_write;
          // A combined read+write encoding is executed as a write only.
          r_cmd_read  <= (|i_d_write) ? 4'd0 : i_d_read;
          r_addr      <= i_d_addr;
          r_wdata     <= i_d_wdata;
          if (i_if_req) begin
            if (r_starve < LP_STARVE) begin
              r_starve <= r_starve + 4'd1;
            end
          end else begin
            r_starve <= '0;
          end
        end else if (i_if_req) begin
          r_owner_d   <= 1'b0;
          r_cmd_read  <= LP_IF_CMD;
          r_cmd_write <= '0;
          r_addr      <= i_if_addr;
          r_wdata     <= '0;
          r_starve    <= '0;
        end
      end else if (w_grant) begin
        if (i_m_ready) begin
          if (|r_cmd_read) begin
            if (r_owner_d) begin
              r_d_rdata <= i_m_rdata;
            end else begin
              r_if_rdata <= i_m_rdata;
            end
          end
        end else if (w_timeout) begin
          r_err <= 1'b1;
          if (r_owner_d) begin
            r_d_rdata <= '0;
          end else begin
            r_if_rdata <= '0;
          end
        end else begin
          r_tmo <= r_tmo + 8'd1;
        end
      end
    end
  end

  assign o_m_read      = w_grant ? r_cmd_read : 4'd0;
  assign o_m_write     = w_grant ? r_cmd_write : 3'd0;
  assign o_m_addr      = r_addr;
  assign o_m_wdata     = r_wdata;
  assign o_if_rdata    = r_if_rdata;
  assign o_d_rdata     = r_d_rdata;
  assign o_err         = r_err;
  assign o_if_busywait = i_if_req && !((r_state == RESP) && !r_owner_d);
  assign o_d_busywait  = w_d_active && !((r_state == RESP) && r_owner_d);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter (STARVE_LIMIT=4, TIMEOUT=8). A
//   transaction-level model tracks which port is being served, how long it
//   has waited and the starvation tally, and a negedge compare process
//   checks every DUT output against it each cycle. The directed sequences
//   also carry literal expectations worked out by hand.

module tb_mem_arbiter;

  localparam int STARVE = 4;
  localparam int TMO    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_busy;
  logic [3:0]  d_read;
  logic [2:0]  d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_busy;
  logic [3:0]  m_read;
  logic [2:0]  m_write;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(STARVE), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_rdata(if_rdata), .o_if_busywait(if_busy),
    .i_d_read(d_read), .i_d_write(d_write),
    .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_d_rdata(d_rdata), .o_d_busywait(d_busy),
    .o_m_read(m_read), .o_m_write(m_write),
    .o_m_addr(m_addr), .o_m_wdata(m_wdata),
    .i_m_rdata(m_rdata), .i_m_ready(m_ready),
    .o_err(err)
  );

  // Single comparison point shared by the model checker and the
  // hand-computed expectations.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: phase 0 = nobody served, 1 = a port is being served
  // by memory, 2 = the served port gets its answer.
  bit          mValid = 1'b0;
  int          mPhase;
  bit          mOwnerD;
  logic [3:0]  mRd;
  logic [2:0]  mWr;
  logic [31:0] mAddr, mWdata, mIfData, mDData;
  int          mAge, mStarve;
  bit          mErr;
  bit          mDAct;

  always @(posedge clk) begin
    if (rst) begin
      mValid = 1'b1; mPhase = 0; mOwnerD = 1'b0; mRd = '0; mWr = '0;
      mAddr = '0; mWdata = '0; mIfData = '0; mDData = '0;
      mAge = 0; mStarve = 0; mErr = 1'b0;
    end else if (mValid) begin
      mDAct = (d_read != 0) || (d_write != 0);
      case (mPhase)
        0: begin
          mErr = 1'b0;
          if (mDAct && (mStarve < STARVE || !if_req)) begin
            mOwnerD = 1'b1; mWr = d_write;
            mRd = (d_write != 0) ? 4'd0 : d_read;
            mAddr = d_addr; mWdata = d_wdata; mAge = 0; mPhase = 1;
            mStarve = if_req ? ((mStarve + 1 > STARVE) ? STARVE : mStarve + 1) : 0;
          end else if (if_req) begin
            mOwnerD = 1'b0; mRd = 4'b0010; mWr = '0;
            mAddr = if_addr; mWdata = '0; mAge = 0; mStarve = 0; mPhase = 1;
          end
        end
        1: begin
          mAge++;
          if (m_ready) begin
            mPhase = 2;
            if (mRd != 0) begin
              if (mOwnerD) mDData = m_rdata;
              else         mIfData = m_rdata;
            end
          end else if (mAge == TMO) begin
            mPhase = 2; mErr = 1'b1;
            if (mOwnerD) mDData = '0;
            else         mIfData = '0;
          end
        end
        default: begin
          mPhase = 0; mErr = 1'b0;
        end
      endcase
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (mValid) begin
      checkOutput("m_read",   {28'd0, m_read},  (mPhase == 1) ? {28'd0, mRd} : 32'd0);
      checkOutput("m_write",  {29'd0, m_write}, (mPhase == 1) ? {29'd0, mWr} : 32'd0);
      checkOutput("m_addr",   m_addr,   mAddr);
      checkOutput("m_wdata",  m_wdata,  mWdata);
      checkOutput("if_rdata", if_rdata, mIfData);
      checkOutput("d_rdata",  d_rdata,  mDData);
      checkOutput("err",      {31'd0, err}, {31'd0, mErr});
      checkOutput("if_busy",  {31'd0, if_busy},
                  {31'd0, if_req && !(mPhase == 2 && !mOwnerD)});
      checkOutput("d_busy",   {31'd0, d_busy},
                  {31'd0, ((d_read != 0) || (d_write != 0)) && !(mPhase == 2 && mOwnerD)});
    end
  end

  logic [5:0] seq;
  int         nGrants;

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_read = '0; d_write = '0;
    d_addr = '0; d_wdata = '0; m_rdata = '0; m_ready = 1'b0;

    // Reset held with a pending fetch: stall visible, no grant.
    applyStimulus();
    applyStimulus();
    if_req = 1'b1;
    #1;
    checkOutput("rst if_busy", {31'd0, if_busy}, 32'd1);
    applyStimulus();
    checkOutput("rst no grant", {28'd0, m_read}, 32'd0);
    rst = 1'b0; if_req = 1'b0;
    applyStimulus();

    // IF-only read, minimum latency.
    if_req = 1'b1; if_addr = 32'h40;
    applyStimulus();
    checkOutput("if m_read", {28'd0, m_read}, 32'h2);
    checkOutput("if m_addr", m_addr, 32'h40);
    m_ready = 1'b1; m_rdata = 32'h00500093;
    applyStimulus();
    checkOutput("if busy low", {31'd0, if_busy}, 32'd0);
    checkOutput("if rdata", if_rdata, 32'h00500093);
    if_req = 1'b0; m_ready = 1'b0;
    applyStimulus();

    // Request withdrawn mid-grant with the address changing underneath.
    if_req = 1'b1; if_addr = 32'h44;
    applyStimulus();
    if_req = 1'b0; if_addr = 32'h99; m_ready = 1'b1; m_rdata = 32'h0BADCAFE;
    #1;
    checkOutput("wd m_addr held", m_addr, 32'h44);
    applyStimulus();
    checkOutput("wd rdata", if_rdata, 32'h0BADCAFE);
    m_ready = 1'b0;
    applyStimulus();

    // Simultaneous IF read and D write: D first, IF one idle cycle later.
    if_req = 1'b1; if_addr = 32'h0;
    d_write = 3'b010; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
    applyStimulus();
    checkOutput("sim m_write", {29'd0, m_write}, 32'h2);
    checkOutput("sim m_addr", m_addr, 32'h100);
    checkOutput("sim m_wdata", m_wdata, 32'hDEADBEEF);
    m_ready = 1'b1; m_rdata = 32'h77;
    applyStimulus();
    checkOutput("sim d_busy", {31'd0, d_busy}, 32'd0);
    checkOutput("sim if_busy", {31'd0, if_busy}, 32'd1);
    d_write = '0; m_ready = 1'b0;
    applyStimulus();
    checkOutput("sim idle gap", {28'd0, m_read}, 32'd0);
    applyStimulus();
    checkOutput("sim if grant", {28'd0, m_read}, 32'h2);
    checkOutput("sim if addr", m_addr, 32'h0);
    m_ready = 1'b1; m_rdata = 32'h13;
    applyStimulus();
    if_req = 1'b0; m_ready = 1'b0;
    applyStimulus();

    // Starvation: D held with IF waiting -> D D D D IF D.
    if_req = 1'b1; if_addr = 32'h80; d_read = 4'b0010; d_addr = 32'h200;
    m_ready = 1'b1; m_rdata = 32'h12345678;
    seq = '0; nGrants = 0;
    for (int i = 0; i < 18; i++) begin
      applyStimulus();
      if (m_read != 0) begin
        seq = {seq[4:0], m_addr == 32'h200};
        nGrants++;
      end
    end
    if_req = 1'b0; d_read = '0; m_ready = 1'b0;
    checkOutput("starve grants", nGrants, 32'd6);
    checkOutput("starve order", {26'd0, seq}, 32'b111101);
    applyStimulus();

    // Timeout on a D read.
    d_read = 4'b0010; d_addr = 32'h300;
    for (int i = 0; i < TMO; i++) begin
      applyStimulus();
      checkOutput("tmo granted", {28'd0, m_read}, 32'h2);
    end
    applyStimulus();
    checkOutput("tmo err", {31'd0, err}, 32'd1);
    checkOutput("tmo d_busy", {31'd0, d_busy}, 32'd0);
    checkOutput("tmo d_rdata", d_rdata, 32'h0);
    d_read = '0;
    applyStimulus();
    checkOutput("tmo err drop", {31'd0, err}, 32'd0);

    // Load a known D_RDATA, then a combined read+write runs as a write.
    d_read = 4'b0010; d_addr = 32'h500;
    applyStimulus();
    m_ready = 1'b1; m_rdata = 32'hA5A50001;
    applyStimulus();
    d_read = '0; m_ready = 1'b0;
    applyStimulus();
    d_read = 4'b0100; d_write = 3'b001; d_addr = 32'h400; d_wdata = 32'hCAFEF00D;
    applyStimulus();
    checkOutput("rw m_write", {29'd0, m_write}, 32'h1);
    checkOutput("rw m_read", {28'd0, m_read}, 32'h0);
    m_ready = 1'b1; m_rdata = 32'hFFFFFFFF;
    applyStimulus();
    checkOutput("rw d_rdata kept", d_rdata, 32'hA5A50001);
    d_read = '0; d_write = '0; m_ready = 1'b0;
    applyStimulus();

    // Reset in the second GRANT_D cycle, then a late M_READY.
    d_write = 3'b010; d_addr = 32'h600; d_wdata = 32'h11112222;
    applyStimulus();
    applyStimulus();
    checkOutput("mid g2 write", {29'd0, m_write}, 32'h2);
    rst = 1'b1; d_write = '0;
    applyStimulus();
    checkOutput("mid m_write", {29'd0, m_write}, 32'h0);
    checkOutput("mid m_addr", m_addr, 32'h0);
    checkOutput("mid m_wdata", m_wdata, 32'h0);
    checkOutput("mid if_rdata", if_rdata, 32'h0);
    checkOutput("mid d_rdata", d_rdata, 32'h0);
    rst = 1'b0; m_ready = 1'b1; m_rdata = 32'hEEEE;
    applyStimulus();
    checkOutput("late ready m_read", {28'd0, m_read}, 32'h0);
    checkOutput("late ready d_rdata", d_rdata, 32'h0);
    m_ready = 1'b0;
    applyStimulus();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
